// File: rtl/dds_uart_pkg.sv
// Shared constants and the decoder state encoding for the UART command decoder.
// The ACK state is only reachable when UART_WRITE_ACK_EN is defined.
package dds_uart_pkg;

  localparam logic [7:0] CMD_WR_DEFAULT = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD_DEFAULT = 8'h52;  // 'R'
  localparam logic [7:0] ACK_BYTE       = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    SEND,
    ACK
  } state_t;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Bundle of the decoder's UART-side, register-side and status signals.
// TX handshake: a byte transfers on every clock edge where tx_valid_o & tx_ready_i;
// while tx_valid_o is high without tx_ready_i, tx_data_o holds steady.
interface uart_cmd_decoder_if;

  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic [7:0] tx_data_o;
  logic       reg_wr_o;
  logic       reg_rd_o;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_data_o;
  logic [7:0] reg_data_i;
  logic       frame_err_o;
  logic       busy_o;

  modport master (
    input  rx_valid_i, rx_data_i, tx_ready_i, reg_data_i,
    output tx_valid_o, tx_data_o, reg_wr_o, reg_rd_o, reg_addr_o, reg_data_o,
           frame_err_o, busy_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, tx_ready_i, reg_data_i,
    input  tx_valid_o, tx_data_o, reg_wr_o, reg_rd_o, reg_addr_o, reg_data_o,
           frame_err_o, busy_o
  );

endinterface

// File: rtl/frame_timer.sv
// Inter-byte watchdog: counts while run_i, restarts on clr_i, and pulses expired_o
// in the last allowed cycle. TIMEOUT_CYCLES = 0 disables it entirely.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, run_i, clr_i};
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Holds at LAST so a stalled caller never sees the counter wrap.
      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (run_i && (cnt_q != LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired_o = run_i && !clr_i && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses 'W' addr data / 'R' addr frames into register strobes and returns read data
// over the TX handshake. Define UART_WRITE_ACK_EN to answer each write with ACK_BYTE.
module uart_cmd_decoder
  import dds_uart_pkg::*;
#(
  parameter logic [7:0]  CMD_WR         = CMD_WR_DEFAULT,
  parameter logic [7:0]  CMD_RD         = CMD_RD_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_cmd_decoder_if.master    bus,
  output state_t                state_o
);

  state_t     state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;

  logic tmr_run, tmr_clr, tmr_expired;

  assign tmr_run = (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign tmr_clr = bus.rx_valid_i || !tmr_run;

  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run_i     (tmr_run),
    .clr_i     (tmr_clr),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_valid_i) begin
          if (bus.rx_data_i == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = GET_ADDR;
          end else if (bus.rx_data_i == CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = GET_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // A byte in the expiry cycle takes priority over the timeout.
      GET_ADDR: begin
        if (bus.rx_valid_i) begin
          addr_d  = bus.rx_data_i;
          state_d = is_wr_q ? GET_DATA : READ;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      GET_DATA: begin
        if (bus.rx_valid_i) begin
          data_d  = bus.rx_data_i;
          state_d = WRITE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
`ifdef UART_WRITE_ACK_EN
        state_d = ACK;
`else
        state_d = IDLE;
`endif
      end
      READ: begin
        rdata_d = bus.reg_data_i;
        state_d = SEND;
      end
      SEND: begin
        if (bus.tx_ready_i) state_d = IDLE;
      end
      ACK: begin
`ifdef UART_WRITE_ACK_EN
        if (bus.tx_ready_i) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Address and data buses are forced to zero outside the strobe cycles.
  assign bus.reg_wr_o   = (state_q == WRITE);
  assign bus.reg_rd_o   = (state_q == READ);
  assign bus.reg_addr_o = (bus.reg_wr_o || bus.reg_rd_o) ? addr_q : 8'h00;
  assign bus.reg_data_o = bus.reg_wr_o ? data_q : 8'h00;

  always_comb begin
    bus.tx_valid_o = 1'b0;
    bus.tx_data_o  = 8'h00;
    if (state_q == SEND) begin
      bus.tx_valid_o = 1'b1;
      bus.tx_data_o  = rdata_q;
    end
`ifdef UART_WRITE_ACK_EN
    else if (state_q == ACK) begin
      bus.tx_valid_o = 1'b1;
      bus.tx_data_o  = ACK_BYTE;
    end
`endif
  end

  assign bus.frame_err_o = err_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign state_o         = state_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a frame-level model checked every cycle,
// plus hand-computed expectations at the interesting cycles of each scenario.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;
  import dds_uart_pkg::*;

  localparam int unsigned TO = 16;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_o;

  always #5 clk = ~clk;

  uart_cmd_decoder_if bus();

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- register file stand-in ----------------
  logic [7:0] mem [256];
  assign bus.reg_data_i = bus.reg_rd_o ? mem[bus.reg_addr_o] : 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[2] <= 8'hA5;
    end else if (bus.reg_wr_o) begin
      mem[bus.reg_addr_o] <= bus.reg_data_o;
    end
  end

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // frm holds the bytes of the frame being collected; exp_q holds bytes owed to TX.
  logic [7:0] frm[$];
  logic [7:0] exp_q[$];
  logic [7:0] mmem [256];
  bit         m_wr, m_rd, m_err;
  logic [7:0] m_addr, m_data;
  int         gap;

  always @(posedge clk) begin
    if (rst) begin
      frm.delete();
      exp_q.delete();
      m_wr = 0; m_rd = 0; m_err = 0; gap = 0;
      m_addr = 8'h00; m_data = 8'h00;
      for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
      mmem[2] = 8'hA5;
    end else begin
      m_err = 0;
      if (m_wr) begin
        mmem[m_addr] = m_data;
        m_wr = 0;
`ifdef UART_WRITE_ACK_EN
        exp_q.push_back(8'h06);
`endif
      end else if (m_rd) begin
        exp_q.push_back(mmem[m_addr]);
        m_rd = 0;
      end else if (exp_q.size() != 0) begin
        if (bus.tx_ready_i) void'(exp_q.pop_front());
      end else if (frm.size() == 0) begin
        if (bus.rx_valid_i) begin
          if (bus.rx_data_i == 8'h57 || bus.rx_data_i == 8'h52) begin
            frm.push_back(bus.rx_data_i);
            gap = 0;
          end else begin
            m_err = 1;
          end
        end
      end else begin
        if (bus.rx_valid_i) begin
          frm.push_back(bus.rx_data_i);
          gap = 0;
          if (frm[0] == 8'h52 && frm.size() == 2) begin
            m_rd = 1; m_addr = frm[1]; frm.delete();
          end else if (frm.size() == 3) begin
            m_wr = 1; m_addr = frm[1]; m_data = frm[2]; frm.delete();
          end
        end else if (TO != 0 && gap == int'(TO) - 1) begin
          frm.delete();
          m_err = 1;
        end else begin
          gap++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk1("m_reg_wr", bus.reg_wr_o, m_wr);
    chk1("m_reg_rd", bus.reg_rd_o, m_rd);
    chk8("m_reg_addr", bus.reg_addr_o, (m_wr || m_rd) ? m_addr : 8'h00);
    chk8("m_reg_data", bus.reg_data_o, m_wr ? m_data : 8'h00);
    chk1("m_frame_err", bus.frame_err_o, m_err);
    chk1("m_busy", bus.busy_o, (frm.size() != 0) || m_wr || m_rd || (exp_q.size() != 0));
    chk1("m_tx_valid", bus.tx_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) chk8("m_tx_data", bus.tx_data_o, exp_q[0]);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    tick(1);
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
  endtask

  // Called in the cycle right after a WRITE cycle.
  task automatic after_write();
`ifdef UART_WRITE_ACK_EN
    chk1("ack_valid", bus.tx_valid_o, 1'b1);
    chk8("ack_byte", bus.tx_data_o, 8'h06);
    bus.tx_ready_i = 1'b1;
    tick(1);
    bus.tx_ready_i = 1'b0;
    chk1("ack_drop", bus.tx_valid_o, 1'b0);
`else
    chk1("no_tx_on_write", bus.tx_valid_o, 1'b0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.tx_ready_i = 1'b0;
    rst = 1'b1;
    tick(2);
    chk1("rst_wr", bus.reg_wr_o, 1'b0);
    chk1("rst_rd", bus.reg_rd_o, 1'b0);
    chk1("rst_tx_valid", bus.tx_valid_o, 1'b0);
    chk8("rst_tx_data", bus.tx_data_o, 8'h00);
    chk1("rst_err", bus.frame_err_o, 1'b0);
    chk1("rst_busy", bus.busy_o, 1'b0);
    chk8("rst_addr", bus.reg_addr_o, 8'h00);
    chk1("rst_state_idle", state_o == IDLE, 1'b1);
    rst = 1'b0;
    tick(1);

    // Write frame with 5-cycle gaps.
    send_byte(8'h57); tick(5);
    send_byte(8'h01); tick(5);
    send_byte(8'h3C);
    chk1("wr_strobe", bus.reg_wr_o, 1'b1);
    chk8("wr_addr", bus.reg_addr_o, 8'h01);
    chk8("wr_data", bus.reg_data_o, 8'h3C);
    chk1("wr_no_rd", bus.reg_rd_o, 1'b0);
    tick(1);
    chk1("wr_one_cycle", bus.reg_wr_o, 1'b0);
    after_write();
    tick(2);

    // Read frame, transmitter stalled for 10 cycles, bytes during SEND ignored.
    send_byte(8'h52); tick(3);
    send_byte(8'h02);
    chk1("rd_strobe", bus.reg_rd_o, 1'b1);
    chk8("rd_addr", bus.reg_addr_o, 8'h02);
    chk1("rd_no_wr", bus.reg_wr_o, 1'b0);
    tick(1);
    for (int i = 0; i < 10; i++) begin
      chk1("send_hold_valid", bus.tx_valid_o, 1'b1);
      chk8("send_hold_data", bus.tx_data_o, 8'hA5);
      if (i == 3) send_byte(8'h57);
      else if (i == 5) send_byte(8'h52);
      else tick(1);
    end
    bus.tx_ready_i = 1'b1;
    tick(1);
    bus.tx_ready_i = 1'b0;
    chk1("send_drop", bus.tx_valid_o, 1'b0);
    chk1("send_idle", bus.busy_o, 1'b0);
    tick(3);

    // Read back the written register with tx_ready held high.
    bus.tx_ready_i = 1'b1;
    send_byte(8'h52);
    send_byte(8'h01);
    chk1("rb_strobe", bus.reg_rd_o, 1'b1);
    tick(1);
    chk1("rb_valid", bus.tx_valid_o, 1'b1);
    chk8("rb_data", bus.tx_data_o, 8'h3C);
    tick(1);
    chk1("rb_drop", bus.tx_valid_o, 1'b0);
    bus.tx_ready_i = 1'b0;
    tick(2);

    // Unknown command.
    send_byte(8'h41);
    chk1("unk_err", bus.frame_err_o, 1'b1);
    chk1("unk_busy", bus.busy_o, 1'b0);
    tick(1);
    chk1("unk_err_pulse", bus.frame_err_o, 1'b0);
    tick(2);

    // Timeout after the address byte.
    send_byte(8'h57);
    send_byte(8'h01);
    for (int k = 1; k <= int'(TO); k++) begin
      chk1("to_wait_err", bus.frame_err_o, 1'b0);
      chk1("to_wait_busy", bus.busy_o, 1'b1);
      tick(1);
    end
    chk1("to_err", bus.frame_err_o, 1'b1);
    chk1("to_busy_fall", bus.busy_o, 1'b0);
    tick(2);
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h01);
    chk1("post_to_wr", bus.reg_wr_o, 1'b1);
    chk8("post_to_addr", bus.reg_addr_o, 8'h00);
    chk8("post_to_data", bus.reg_data_o, 8'h01);
    tick(1);
    after_write();
    tick(2);

    // Data byte arriving exactly in the expiry cycle.
    send_byte(8'h57);
    send_byte(8'h01);
    tick(int'(TO) - 1);
    send_byte(8'h77);
    chk1("edge_wr", bus.reg_wr_o, 1'b1);
    chk8("edge_data", bus.reg_data_o, 8'h77);
    chk1("edge_no_err", bus.frame_err_o, 1'b0);
    tick(1);
    chk1("edge_no_err_late", bus.frame_err_o, 1'b0);
    after_write();
    tick(2);

    // Reset while a read response is pending.
    send_byte(8'h52);
    send_byte(8'h02);
    tick(1);
    chk1("pre_rst_valid", bus.tx_valid_o, 1'b1);
    chk8("pre_rst_data", bus.tx_data_o, 8'hA5);
    rst = 1'b1;
    tick(1);
    chk1("rst_send_valid", bus.tx_valid_o, 1'b0);
    chk1("rst_send_idle", state_o == IDLE, 1'b1);
    chk1("rst_send_busy", bus.busy_o, 1'b0);
    rst = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
